tbus_arbiter: RTL and testbench

//  Shares the single dcache trinity-bus (tbus) port between the load unit (ldu) and the store-queue drain (sq).
//  - Grant is locked per transaction: index handshake, then wait for operation_done.
//  - Default priority goes to loads; an anti-starvation counter forces an sq grant.
//  - Sits between memblock/storequeue and dcache.

---
 rtl/tbus_pkg.sv | 18 +
 rtl/tbus_arb_sel.sv | 46 ++++
 rtl/tbus_arbiter.sv | 136 +++++++++++++
 tb/tb_tbus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbus_pkg.sv
// Shared types and constants for the dcache tbus arbiter.
package tbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } tbus_arb_state_t;

  typedef enum logic {
    OWN_LDU = 1'b0,
    OWN_SQ  = 1'b1
  } tbus_owner_t;

  localparam logic [1:0] TBUS_OP_READ  = 2'd0;
  localparam logic [1:0] TBUS_OP_WRITE = 2'd1;

endpackage

// File: rtl/tbus_arb_sel.sv
// Winner selection between ldu and sq, plus the anti-starvation streak counter.
module tbus_arb_sel
  import tbus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ldu_valid,
  input  logic        sq_valid,
  input  logic        accept,
  input  tbus_owner_t accept_owner,
  output tbus_owner_t winner
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] ld_streak;

  // Loads win by default; a waiting store wins when alone or once loads have used up their streak.
  always_comb begin
    winner = OWN_LDU;
    if (sq_valid && (!ldu_valid || (ld_streak == LIMIT))) begin
      winner = OWN_SQ;
    end
  end

  // Count load grants taken while a store was waiting; updated only when dcache accepts.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ld_streak <= '0;
    end else if (accept) begin
      if (accept_owner == OWN_SQ) begin
        ld_streak <= '0;
      end else if (sq_valid) begin
        if (ld_streak != LIMIT) begin
          ld_streak <= ld_streak + 1'b1;
        end
      end else begin
        ld_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// Shares the single dcache tbus port between the load unit and the store-queue drain.
// One transaction in flight; the grant is held from index handshake until operation_done.
module tbus_arbiter
  import tbus_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MASK_W       = 64,
  parameter int OPTYPE_W     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  // load unit
  input  logic                ldu_index_valid,
  output logic                ldu_index_ready,
  input  logic [ADDR_W-1:0]   ldu_index,
  input  logic [DATA_W-1:0]   ldu_write_data,
  input  logic [MASK_W-1:0]   ldu_write_mask,
  input  logic [OPTYPE_W-1:0] ldu_operation_type,
  output logic [DATA_W-1:0]   ldu_read_data,
  output logic                ldu_operation_done,
  // store-queue drain
  input  logic                sq_index_valid,
  output logic                sq_index_ready,
  input  logic [ADDR_W-1:0]   sq_index,
  input  logic [DATA_W-1:0]   sq_write_data,
  input  logic [MASK_W-1:0]   sq_write_mask,
  input  logic [OPTYPE_W-1:0] sq_operation_type,
  output logic [DATA_W-1:0]   sq_read_data,
  output logic                sq_operation_done,
  // dcache
  output logic                arb2dcache_index_valid,
  input  logic                arb2dcache_index_ready,
  output logic [ADDR_W-1:0]   arb2dcache_index,
  output logic [DATA_W-1:0]   arb2dcache_write_data,
  output logic [MASK_W-1:0]   arb2dcache_write_mask,
  output logic [OPTYPE_W-1:0] arb2dcache_operation_type,
  input  logic [DATA_W-1:0]   arb2dcache_read_data,
  input  logic                arb2dcache_operation_done,
  output logic                arb_busy
);

  tbus_arb_state_t state, state_nxt;
  tbus_owner_t     owner, winner;
  logic            own_valid;
  logic            accept;

  assign own_valid = (owner == OWN_SQ) ? sq_index_valid : ldu_index_valid;
  assign accept    = (state == REQ) && own_valid && arb2dcache_index_ready;
  assign arb_busy  = (state != IDLE);

  tbus_arb_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clock       (clock),
    .reset_n     (reset_n),
    .ldu_valid   (ldu_index_valid),
    .sq_valid    (sq_index_valid),
    .accept      (accept),
    .accept_owner(owner),
    .winner      (winner)
  );

  // State register; the owner is latched during the IDLE arbitration bubble.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= OWN_LDU;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (ldu_index_valid || sq_index_valid)) begin
        owner <= winner;
      end
    end
  end

  // Next-state and request/response routing for the current owner.
  always_comb begin
    state_nxt                 = state;
    arb2dcache_index_valid    = 1'b0;
    arb2dcache_index          = '0;
    arb2dcache_write_data     = '0;
    arb2dcache_write_mask     = '0;
    arb2dcache_operation_type = '0;
    ldu_index_ready           = 1'b0;
    sq_index_ready            = 1'b0;
    ldu_read_data             = '0;
    sq_read_data              = '0;
    ldu_operation_done        = 1'b0;
    sq_operation_done         = 1'b0;
    case (state)
      IDLE: begin
        if (ldu_index_valid || sq_index_valid) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (owner == OWN_SQ) begin
          arb2dcache_index          = sq_index;
          arb2dcache_write_data     = sq_write_data;
          arb2dcache_write_mask     = sq_write_mask;
          arb2dcache_operation_type = sq_operation_type;
          sq_index_ready            = arb2dcache_index_ready;
        end else begin
          arb2dcache_index          = ldu_index;
          arb2dcache_write_data     = ldu_write_data;
          arb2dcache_write_mask     = ldu_write_mask;
          arb2dcache_operation_type = ldu_operation_type;
          ldu_index_ready           = arb2dcache_index_ready;
        end
        arb2dcache_index_valid = own_valid;
        if (accept) begin
          state_nxt = WAIT;
        end else if (!own_valid) begin
          // owner withdrew (load flush) before dcache took the request
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (arb2dcache_operation_done) begin
          if (owner == OWN_SQ) begin
            sq_operation_done = 1'b1;
            sq_read_data      = arb2dcache_read_data;
          end else begin
            ldu_operation_done = 1'b1;
            ldu_read_data      = arb2dcache_read_data;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: directed scenarios plus randomized traffic
// checked against a grant-order reference model.
module tb_tbus_arbiter;
  import tbus_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 64;
  localparam int OW = 2;
  localparam int LIMIT = 4;

  logic          clock;
  logic          reset_n;
  logic          ldu_index_valid, ldu_index_ready;
  logic [AW-1:0] ldu_index;
  logic [DW-1:0] ldu_write_data, ldu_read_data;
  logic [MW-1:0] ldu_write_mask;
  logic [OW-1:0] ldu_operation_type;
  logic          ldu_operation_done;
  logic          sq_index_valid, sq_index_ready;
  logic [AW-1:0] sq_index;
  logic [DW-1:0] sq_write_data, sq_read_data;
  logic [MW-1:0] sq_write_mask;
  logic [OW-1:0] sq_operation_type;
  logic          sq_operation_done;
  logic          arb2dcache_index_valid;
  logic          dc_ready;
  logic [AW-1:0] arb2dcache_index;
  logic [DW-1:0] arb2dcache_write_data;
  logic [MW-1:0] arb2dcache_write_mask;
  logic [OW-1:0] arb2dcache_operation_type;
  logic [DW-1:0] dc_rdata;
  logic          dc_done;
  logic          arb_busy;

  int vectors = 0;
  int miscompares = 0;
  int m_streak = 0;

  tbus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .OPTYPE_W(OW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .ldu_index_valid          (ldu_index_valid),
    .ldu_index_ready          (ldu_index_ready),
    .ldu_index                (ldu_index),
    .ldu_write_data           (ldu_write_data),
    .ldu_write_mask           (ldu_write_mask),
    .ldu_operation_type       (ldu_operation_type),
    .ldu_read_data            (ldu_read_data),
    .ldu_operation_done       (ldu_operation_done),
    .sq_index_valid           (sq_index_valid),
    .sq_index_ready           (sq_index_ready),
    .sq_index                 (sq_index),
    .sq_write_data            (sq_write_data),
    .sq_write_mask            (sq_write_mask),
    .sq_operation_type        (sq_operation_type),
    .sq_read_data             (sq_read_data),
    .sq_operation_done        (sq_operation_done),
    .arb2dcache_index_valid   (arb2dcache_index_valid),
    .arb2dcache_index_ready   (dc_ready),
    .arb2dcache_index         (arb2dcache_index),
    .arb2dcache_write_data    (arb2dcache_write_data),
    .arb2dcache_write_mask    (arb2dcache_write_mask),
    .arb2dcache_operation_type(arb2dcache_operation_type),
    .arb2dcache_read_data     (dc_rdata),
    .arb2dcache_operation_done(dc_done),
    .arb_busy                 (arb_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: who wins the next grant, and how the load streak evolves.
  function automatic int model_pick(bit lv, bit sv);
    return (sv && (!lv || m_streak == LIMIT)) ? 1 : 0;
  endfunction

  function automatic void model_accept(int w, bit sv);
    if (w == 1) m_streak = 0;
    else if (sv) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
    else m_streak = 0;
  endfunction

  // Acts as dcache for one transaction starting in IDLE; reports what it saw.
  task automatic do_txn(input int rdy_dly, input int done_dly, input logic [DW-1:0] rdata,
                        input bit keep_l, input bit keep_s,
                        output int win, output logic [AW-1:0] f_idx, output logic [DW-1:0] f_wd,
                        output logic [MW-1:0] f_wm, output logic [OW-1:0] f_op,
                        output int req_err, output int l_done_n, output int s_done_n,
                        output logic [DW-1:0] l_rd, output logic [DW-1:0] s_rd, output bit tmo);
    int n;
    bit hs;
    win = -1; req_err = 0; l_done_n = 0; s_done_n = 0; l_rd = '0; s_rd = '0; tmo = 1'b0;
    f_idx = '0; f_wd = '0; f_wm = '0; f_op = '0;
    dc_ready = 1'b0; dc_done = 1'b0;
    #1;
    n = 0;
    while (arb2dcache_index_valid !== 1'b1 && n < 8) begin
      @(negedge clock); #1; n++;
    end
    if (arb2dcache_index_valid !== 1'b1) begin tmo = 1'b1; return; end
    hs = 1'b0; n = 0;
    while (!hs && n < 16) begin
      dc_ready = (n >= rdy_dly); #1;
      if (ldu_index_ready === 1'b1 && sq_index_ready === 1'b1) req_err++;
      if ((ldu_index_ready | sq_index_ready) !== dc_ready) req_err++;
      if (arb2dcache_index_valid !== 1'b1 || arb_busy !== 1'b1) req_err++;
      if (dc_ready) begin
        hs = 1'b1;
        win = (ldu_index_ready === 1'b1) ? 0 : ((sq_index_ready === 1'b1) ? 1 : -1);
        f_idx = arb2dcache_index; f_wd = arb2dcache_write_data;
        f_wm = arb2dcache_write_mask; f_op = arb2dcache_operation_type;
      end
      @(negedge clock); n++;
    end
    dc_ready = 1'b0;
    if (!hs) begin tmo = 1'b1; return; end
    if (win == 0) begin
      if (keep_l) ldu_index = ldu_index + 64; else ldu_index_valid = 1'b0;
    end else if (win == 1) begin
      if (keep_s) sq_index = sq_index + 64; else sq_index_valid = 1'b0;
    end
    for (int i = 0; i < done_dly; i++) begin
      #1;
      if (arb2dcache_index_valid !== 1'b0 || arb_busy !== 1'b1) req_err++;
      if (ldu_operation_done === 1'b1) l_done_n++;
      if (sq_operation_done === 1'b1) s_done_n++;
      @(negedge clock);
    end
    dc_done = 1'b1; dc_rdata = rdata; #1;
    if (ldu_operation_done === 1'b1) l_done_n++;
    if (sq_operation_done === 1'b1) s_done_n++;
    l_rd = ldu_read_data; s_rd = sq_read_data;
    @(negedge clock);
    dc_done = 1'b0; dc_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ldu_index_valid = 1'b1; ldu_index = 64'h40; dc_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    vectors++;
    if ({arb2dcache_index_valid, ldu_index_ready, sq_index_ready, ldu_operation_done,
         sq_operation_done, arb_busy} !== 6'b0)
      begin miscompares++; $display("FAIL reset_ctrl: got %b want 000000", {arb2dcache_index_valid,
        ldu_index_ready, sq_index_ready, ldu_operation_done, sq_operation_done, arb_busy}); end
    vectors++;
    if (arb2dcache_index !== '0 || ldu_read_data !== '0 || sq_read_data !== '0)
      begin miscompares++; $display("FAIL reset_data: index %h rd %h/%h want 0", arb2dcache_index,
        ldu_read_data, sq_read_data); end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); #1;
    vectors++;
    if (arb2dcache_index_valid !== 1'b1 || ldu_index_ready !== 1'b1)
      begin miscompares++; $display("FAIL reset_pre_hs: valid %b ready %b want 1 1",
        arb2dcache_index_valid, ldu_index_ready); end
    @(negedge clock); ldu_index_valid = 1'b0; dc_ready = 1'b0; reset_n = 1'b0; #1;
    vectors++;
    if (arb_busy !== 1'b1) begin miscompares++; $display("FAIL reset_in_wait: busy %b want 1", arb_busy); end
    @(negedge clock); reset_n = 1'b1; dc_done = 1'b1; dc_rdata = 64'hBAD0_BAD0; #1;
    vectors++;
    if (arb_busy !== 1'b0 || ldu_operation_done !== 1'b0 || sq_operation_done !== 1'b0 ||
        ldu_read_data !== '0 || arb2dcache_index_valid !== 1'b0)
      begin miscompares++; $display("FAIL reset_stale_done: busy %b done %b/%b rd %h want all 0",
        arb_busy, ldu_operation_done, sq_operation_done, ldu_read_data); end
    @(negedge clock); dc_done = 1'b0; dc_rdata = '0; #1;
    vectors++;
    if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: busy %b want 0", arb_busy); end
    m_streak = 0;
  endtask

  task automatic test_single_load();
    int w, re, ld, sd; logic [AW-1:0] fi; logic [DW-1:0] fw, lr, sr; logic [MW-1:0] fm;
    logic [OW-1:0] fo; bit t;
    ldu_index_valid = 1'b1; ldu_index = 64'h8000_0040; ldu_operation_type = TBUS_OP_READ;
    ldu_write_data = '0; ldu_write_mask = '0;
    do_txn(2, 3, 64'hDEAD_BEEF, 1'b0, 1'b0, w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
    model_accept(0, 1'b0);
    vectors++; if (t || w !== 0) begin miscompares++; $display("FAIL load_grant: winner %0d tmo %0d want 0", w, t); end
    vectors++; if (fi !== 64'h8000_0040) begin miscompares++; $display("FAIL load_index: got %h want 8000_0040", fi); end
    vectors++; if (ld !== 1 || lr !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL load_done: pulses %0d data %h want 1 deadbeef", ld, lr); end
    vectors++; if (sd !== 0 || sr !== '0) begin miscompares++; $display("FAIL load_sq_quiet: pulses %0d data %h want 0 0", sd, sr); end
    vectors++; if (re !== 0) begin miscompares++; $display("FAIL load_protocol: errors %0d want 0", re); end
  endtask

  task automatic test_simultaneous();
    int w, re, ld, sd, e; logic [AW-1:0] fi; logic [DW-1:0] fw, lr, sr; logic [MW-1:0] fm;
    logic [OW-1:0] fo; bit t;
    ldu_index_valid = 1'b1; ldu_index = 64'h1000; sq_index_valid = 1'b1; sq_index = 64'h2000;
    for (int k = 0; k < 2; k++) begin
      e = model_pick(ldu_index_valid, sq_index_valid);
      model_accept(e, sq_index_valid);
      do_txn(0, 1, 64'(k + 7), 1'b0, 1'b0, w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
      vectors++; if (t || w !== ((k == 0) ? 0 : 1) || w !== e)
        begin miscompares++; $display("FAIL simul_grant%0d: winner %0d want %0d", k, w, e); end
      vectors++; if (fi !== ((k == 0) ? 64'h1000 : 64'h2000))
        begin miscompares++; $display("FAIL simul_index%0d: got %h", k, fi); end
    end
  endtask

  task automatic test_starvation();
    int w, re, ld, sd, e; logic [AW-1:0] fi; logic [DW-1:0] fw, lr, sr; logic [MW-1:0] fm;
    logic [OW-1:0] fo; bit t;
    int order [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    ldu_index_valid = 1'b1; ldu_index = 64'h3000; sq_index_valid = 1'b1; sq_index = 64'h4000;
    for (int k = 0; k < 11; k++) begin
      e = model_pick(1'b1, 1'b1);
      model_accept(e, 1'b1);
      do_txn(k % 2, 1, 64'(k), 1'b1, 1'b1, w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
      vectors++; if (t || w !== e || w !== order[k])
        begin miscompares++; $display("FAIL starve_grant%0d: winner %0d want %0d", k, w, order[k]); end
    end
    ldu_index_valid = 1'b0; sq_index_valid = 1'b0;
  endtask

  task automatic test_flush();
    int w, re, ld, sd, e; logic [AW-1:0] fi; logic [DW-1:0] fw, lr, sr; logic [MW-1:0] fm;
    logic [OW-1:0] fo; bit t;
    @(negedge clock);
    m_streak = 0;
    ldu_index_valid = 1'b1; ldu_index = 64'h5000; sq_index_valid = 1'b1; sq_index = 64'h6000;
    dc_ready = 1'b0;
    @(negedge clock); #1;
    vectors++; if (arb2dcache_index_valid !== 1'b1 || arb2dcache_index !== 64'h5000)
      begin miscompares++; $display("FAIL flush_req: valid %b index %h want 1 5000", arb2dcache_index_valid, arb2dcache_index); end
    ldu_index_valid = 1'b0; #1;
    vectors++; if (arb2dcache_index_valid !== 1'b0 || ldu_index_ready !== 1'b0 || sq_index_ready !== 1'b0)
      begin miscompares++; $display("FAIL flush_drop: valid %b ready %b/%b want 0", arb2dcache_index_valid, ldu_index_ready, sq_index_ready); end
    @(negedge clock); #1;
    vectors++; if (arb_busy !== 1'b0 || arb2dcache_index_valid !== 1'b0)
      begin miscompares++; $display("FAIL flush_idle: busy %b valid %b want 0 0", arb_busy, arb2dcache_index_valid); end
    e = model_pick(1'b0, 1'b1);
    model_accept(e, 1'b1);
    do_txn(1, 2, 64'h77, 1'b0, 1'b0, w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
    vectors++; if (t || w !== 1 || w !== e || fi !== 64'h6000 || sd !== 1 || sr !== 64'h77)
      begin miscompares++; $display("FAIL flush_sq_after: winner %0d index %h done %0d data %h want 1 6000 1 77", w, fi, sd, sr); end
  endtask

  task automatic test_store_write();
    int w, re, ld, sd; logic [AW-1:0] fi; logic [DW-1:0] fw, lr, sr; logic [MW-1:0] fm;
    logic [OW-1:0] fo; bit t;
    sq_index_valid = 1'b1; sq_index = 64'h8000_1000; sq_write_mask = 64'h0000_0000_FFFF_0000;
    sq_write_data = 64'h1234 << 16; sq_operation_type = TBUS_OP_WRITE;
    do_txn(2, 1, '0, 1'b0, 1'b0, w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
    model_accept(1, 1'b1);
    vectors++; if (t || w !== 1) begin miscompares++; $display("FAIL store_grant: winner %0d want 1", w); end
    vectors++; if (fi !== 64'h8000_1000 || fw !== 64'h1234_0000 || fm !== 64'h0000_0000_FFFF_0000 || fo !== TBUS_OP_WRITE)
      begin miscompares++; $display("FAIL store_fields: idx %h data %h mask %h op %0d", fi, fw, fm, fo); end
    vectors++; if (re !== 0) begin miscompares++; $display("FAIL store_ready_mirror: errors %0d want 0", re); end
    vectors++; if (sd !== 1 || ld !== 0) begin miscompares++; $display("FAIL store_done: sq %0d ldu %0d want 1 0", sd, ld); end
  endtask

  task automatic test_random();
    int w, re, ld, sd, e; logic [AW-1:0] fi, ei; logic [DW-1:0] fw, lr, sr, ew, rd;
    logic [MW-1:0] fm, em; logic [OW-1:0] fo, eo; bit t, sv;
    ldu_index_valid = 1'b0; sq_index_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!ldu_index_valid) begin
        ldu_index_valid = 1'($urandom_range(0, 1)); ldu_index = {$urandom, $urandom};
        ldu_write_data = {$urandom, $urandom}; ldu_write_mask = {$urandom, $urandom};
        ldu_operation_type = 2'($urandom_range(0, 1));
      end
      if (!sq_index_valid) begin
        sq_index_valid = 1'($urandom_range(0, 1)); sq_index = {$urandom, $urandom};
        sq_write_data = {$urandom, $urandom}; sq_write_mask = {$urandom, $urandom};
        sq_operation_type = TBUS_OP_WRITE;
      end
      if (!ldu_index_valid && !sq_index_valid) ldu_index_valid = 1'b1;
      sv = sq_index_valid;
      e = model_pick(ldu_index_valid, sv);
      ei = e ? sq_index : ldu_index; ew = e ? sq_write_data : ldu_write_data;
      em = e ? sq_write_mask : ldu_write_mask; eo = e ? sq_operation_type : ldu_operation_type;
      rd = {$urandom, $urandom};
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd, 1'b0, 1'b0,
             w, fi, fw, fm, fo, re, ld, sd, lr, sr, t);
      model_accept(e, sv);
      vectors++; if (t || w !== e) begin miscompares++; $display("FAIL rand_grant%0d: winner %0d want %0d", k, w, e); end
      vectors++; if (fi !== ei || fw !== ew || fm !== em || fo !== eo)
        begin miscompares++; $display("FAIL rand_fields%0d: idx %h want %h data %h want %h", k, fi, ei, fw, ew); end
      vectors++; if (ld !== ((e == 0) ? 1 : 0) || sd !== ((e == 1) ? 1 : 0) ||
                     lr !== ((e == 0) ? rd : '0) || sr !== ((e == 1) ? rd : '0))
        begin miscompares++; $display("FAIL rand_done%0d: done %0d/%0d data %h/%h want owner %0d data %h", k, ld, sd, lr, sr, e, rd); end
      vectors++; if (re !== 0) begin miscompares++; $display("FAIL rand_protocol%0d: errors %0d want 0", k, re); end
    end
    ldu_index_valid = 1'b0; sq_index_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dc_ready = 1'b0; dc_done = 1'b0; dc_rdata = '0;
    ldu_index_valid = 1'b0; ldu_index = '0; ldu_write_data = '0; ldu_write_mask = '0; ldu_operation_type = '0;
    sq_index_valid = 1'b0; sq_index = '0; sq_write_data = '0; sq_write_mask = '0; sq_operation_type = '0;
    test_reset();
    test_single_load();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
